// File: rtl/switch_debouncer.sv
// Per-channel slide-switch debouncer: 2-flop sync, IDLE/COUNTING FSM, edge pulses.
// Optional CHANGE_COUNT output (accepted-edge tally, mod 256) with `define SW_CHANGE_COUNT_EN.
module switch_debouncer #(
  parameter int N               = 6,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         MAX10_CLK1_50,
  input  logic         KEY0,
  input  logic [0:N-1] SW,
  output logic [0:N-1] SW_CLEAN,
  output logic [0:N-1] SW_RISE,
  output logic [0:N-1] SW_FALL,
  output logic         STABLE
`ifdef SW_CHANGE_COUNT_EN
  ,
  output logic [7:0]   CHANGE_COUNT
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } state_t;

  logic [0:N-1] meta_reg;
  logic [0:N-1] sync_reg;
  logic [0:N-1] counting;
  logic         stable_reg;

  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= SW;
      sync_reg <= meta_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      state_t        state_reg, state_next;
      logic [CW-1:0] cnt_reg, cnt_next;
      logic          clean_reg, clean_next;
      logic          rise_reg, rise_next;
      logic          fall_reg, fall_next;

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        clean_next = clean_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state_reg)
          IDLE: begin
            cnt_next = '0;
            if (sync_reg[gi] != clean_reg) begin
              state_next = COUNTING;
              cnt_next   = CW'(1);
            end
          end
          COUNTING: begin
            if (sync_reg[gi] == clean_reg) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
              // Level has held long enough: accept it and emit the edge pulse.
              state_next = IDLE;
              cnt_next   = '0;
              clean_next = sync_reg[gi];
              rise_next  = sync_reg[gi];
              fall_next  = ~sync_reg[gi];
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end
          default: begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        endcase
      end

      always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
        if (!KEY0) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          clean_reg <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          clean_reg <= clean_next;
          rise_reg  <= rise_next;
          fall_reg  <= fall_next;
        end
      end

      assign SW_CLEAN[gi] = clean_reg;
      assign SW_RISE[gi]  = rise_reg;
      assign SW_FALL[gi]  = fall_reg;
      assign counting[gi] = (state_reg == COUNTING);
    end
  endgenerate

  // STABLE is taken from the registered FSM states, hence one cycle behind them.
  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      stable_reg <= 1'b1;
    end else begin
      stable_reg <= ~|counting;
    end
  end

  assign STABLE = stable_reg;

`ifdef SW_CHANGE_COUNT_EN
  logic [7:0] pulse_sum;
  logic [7:0] change_count_reg;

  always_comb begin
    pulse_sum = '0;
    for (int i = 0; i < N; i++) begin
      pulse_sum = pulse_sum + {7'd0, SW_RISE[i]} + {7'd0, SW_FALL[i]};
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      change_count_reg <= '0;
    end else begin
      change_count_reg <= change_count_reg + pulse_sum;
    end
  end

  assign CHANGE_COUNT = change_count_reg;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed self-checking bench for switch_debouncer with N = 6, DEBOUNCE_CYCLES = 4.
// Define SW_CHANGE_COUNT_EN for both files to exercise CHANGE_COUNT.
module tb_switch_debouncer;

  logic       clk;
  logic       key0;
  logic [0:5] sw;
  logic [0:5] sw_clean;
  logic [0:5] sw_rise;
  logic [0:5] sw_fall;
  logic       stable;
`ifdef SW_CHANGE_COUNT_EN
  logic [7:0] change_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  switch_debouncer #(
    .N              (6),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .MAX10_CLK1_50(clk),
    .KEY0         (key0),
    .SW           (sw),
    .SW_CLEAN     (sw_clean),
    .SW_RISE      (sw_rise),
    .SW_FALL      (sw_fall),
    .STABLE       (stable)
`ifdef SW_CHANGE_COUNT_EN
    ,
    .CHANGE_COUNT (change_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one rising edge; outputs are then observed 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rise_cycles;
    int fall_cycles;
    int pulse_step;
    logic [0:5] pulse_val;
    logic saw_unstable;

    key0 = 1'b0;
    sw   = 6'b000000;
    step();
    step();
    check("reset_clean", 32'(sw_clean), 32'h0);
    check("reset_rise", 32'(sw_rise), 32'h0);
    check("reset_fall", 32'(sw_fall), 32'h0);
    check("reset_stable", 32'(stable), 32'h1);
    key0 = 1'b1;

    // Quiet inputs: nothing moves.
    for (int k = 0; k < 6; k++) begin
      step();
      check("idle_clean", 32'(sw_clean), 32'h0);
      check("idle_pulses", 32'({sw_rise, sw_fall}), 32'h0);
      check("idle_stable", 32'(stable), 32'h1);
    end

    // SW[0] rises and holds: accepted on the 6th edge.
    sw[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("sw0_wait_clean", 32'(sw_clean), 32'h0);
      check("sw0_wait_rise", 32'(sw_rise), 32'h0);
    end
    check("sw0_counting_stable", 32'(stable), 32'h0);
    step();
    check("sw0_clean", 32'(sw_clean), 32'(6'b100000));
    check("sw0_rise", 32'(sw_rise), 32'(6'b100000));
    check("sw0_fall", 32'(sw_fall), 32'h0);
    step();
    check("sw0_rise_one_cycle", 32'(sw_rise), 32'h0);
    check("sw0_stable_back", 32'(stable), 32'h1);

    // SW[2] glitch of 3 cycles is rejected.
    sw[2] = 1'b1;
    saw_unstable = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 3) sw[2] = 1'b0;
      if (stable == 1'b0) saw_unstable = 1'b1;
      check("glitch_clean", 32'(sw_clean), 32'(6'b100000));
      check("glitch_pulses", 32'({sw_rise, sw_fall}), 32'h0);
    end
    check("glitch_saw_counting", 32'(saw_unstable), 32'h1);
    check("glitch_stable", 32'(stable), 32'h1);

    // Return SW[0] to 0.
    sw = 6'b000000;
    for (int k = 0; k < 10; k++) step();
    check("sw0_released", 32'(sw_clean), 32'h0);

    // Four channels rise together, then fall together.
    sw = 6'b110011;
    rise_cycles = 0;
    fall_cycles = 0;
    pulse_step  = 0;
    pulse_val   = '0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (sw_rise != 0) begin
        rise_cycles++;
        pulse_step = k;
        pulse_val  = sw_rise;
      end
      if (sw_fall != 0) fall_cycles++;
    end
    check("multi_rise_cycles", 32'(rise_cycles), 32'd1);
    check("multi_rise_step", 32'(pulse_step), 32'd6);
    check("multi_rise_val", 32'(pulse_val), 32'(6'b110011));
    check("multi_rise_nofall", 32'(fall_cycles), 32'd0);
    check("multi_clean_high", 32'(sw_clean), 32'(6'b110011));

    sw = 6'b000000;
    rise_cycles = 0;
    fall_cycles = 0;
    pulse_step  = 0;
    pulse_val   = '0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (sw_fall != 0) begin
        fall_cycles++;
        pulse_step = k;
        pulse_val  = sw_fall;
      end
      if (sw_rise != 0) rise_cycles++;
    end
    check("multi_fall_cycles", 32'(fall_cycles), 32'd1);
    check("multi_fall_step", 32'(pulse_step), 32'd6);
    check("multi_fall_val", 32'(pulse_val), 32'(6'b110011));
    check("multi_fall_norise", 32'(rise_cycles), 32'd0);
    check("multi_clean_low", 32'(sw_clean), 32'h0);

    // Reset in the middle of a count on SW[5].
    sw[5] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("mid_counting", 32'(stable), 32'h0);
    key0 = 1'b0;
    #1;
    check("mid_reset_stable", 32'(stable), 32'h1);
    check("mid_reset_clean", 32'(sw_clean), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("mid_reset_pulses", 32'({sw_rise, sw_fall}), 32'h0);
    end
    key0 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("post_reset_wait", 32'({sw_clean, sw_rise}), 32'h0);
    end
    step();
    check("post_reset_rise", 32'(sw_rise), 32'(6'b000001));
    check("post_reset_clean", 32'(sw_clean), 32'(6'b000001));
    step();
    check("post_reset_rise_one", 32'(sw_rise), 32'h0);

`ifdef SW_CHANGE_COUNT_EN
    key0 = 1'b0;
    sw   = 6'b000000;
    step();
    check("cnt_reset", 32'(change_count), 32'h0);
    key0 = 1'b1;
    for (int t = 0; t < 130; t++) begin
      sw[0] = ~sw[0];
      sw[1] = ~sw[1];
      for (int k = 0; k < 8; k++) step();
      if (t == 0) check("cnt_first_pair", 32'(change_count), 32'd2);
    end
    for (int k = 0; k < 3; k++) step();
    check("cnt_wrap", 32'(change_count), 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
